// File: rtl/button_reader.sv
// button_reader: synchronises, debounces and decodes one raw board button.
// Presents a clean level, one-cycle press/release pulses and a wrapping press counter.
// Optional feature macro: LONG_PRESS_EN builds the hold counter and the long_press pulse.
// Without it, long_press is tied low and LONG_CYCLES has no effect.
// The release pulse port is named release_pulse because "release" is a reserved word.

module button_reader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int PRESS_CNT_W     = 8,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn,
    output logic                   level,
    output logic                   press,
    output logic                   release_pulse,
    output logic                   long_press,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam int            DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE_RAW = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESSING,
        PRESSED,
        RELEASING
    } state_t;

    // Counters shorter than 2 cycles would make the debounce or hold counters degenerate.
    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
            $error("button_reader: DEBOUNCE_CYCLES and LONG_CYCLES must both be >= 2");
        end
    endgenerate

    logic                   sync1;
    logic                   sync2;
    logic                   p;
    state_t                 state;
    state_t                 state_next;
    logic [DW-1:0]          deb_cnt;
    logic [DW-1:0]          deb_next;
    logic                   level_next;
    logic                   press_next;
    logic                   rel_next;
    logic [PRESS_CNT_W-1:0] count_next;

    // The two-flop synchroniser idles at the unpressed pad value, so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign p = ACTIVE_LOW ? ~sync2 : sync2;

    // Debounce FSM: a change is accepted only after p has disagreed with level for DEBOUNCE_CYCLES cycles.
    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        level_next = level;
        press_next = 1'b0;
        rel_next   = 1'b0;
        count_next = press_count;
        case (state)
            RELEASED: begin
                if (p) begin
                    state_next = PRESSING;
                    deb_next   = DW'(1);
                end
            end
            PRESSING: begin
                if (!p) begin
                    state_next = RELEASED;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                    press_next = 1'b1;
                    level_next = 1'b1;
                    count_next = press_count + PRESS_CNT_W'(1);
                end else begin
                    deb_next = deb_cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_next = RELEASING;
                    deb_next   = DW'(1);
                end
            end
            RELEASING: begin
                if (p) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = RELEASED;
                    deb_next   = '0;
                    rel_next   = 1'b1;
                    level_next = 1'b0;
                end else begin
                    deb_next = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                deb_next   = '0;
            end
        endcase
    end

    // State, debounce counter and all user-visible outputs are registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_next;
            deb_cnt       <= deb_next;
            level         <= level_next;
            press         <= press_next;
            release_pulse <= rel_next;
            press_count   <= count_next;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int            HW        = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic          long_done;
    logic          long_done_next;
    logic          long_next;

    // Hold timer runs while debounced-pressed, fires once, freezes, and re-arms on press or release.
    always_comb begin
        hold_next      = hold_cnt;
        long_done_next = long_done;
        long_next      = 1'b0;
        if (press_next || rel_next) begin
            hold_next      = '0;
            long_done_next = 1'b0;
        end else if ((state == PRESSED || state == RELEASING) && !long_done) begin
            if (hold_cnt == HOLD_LAST) begin
                long_next      = 1'b1;
                long_done_next = 1'b1;
            end else begin
                hold_next = hold_cnt + HW'(1);
            end
        end
    end

    // Hold timer registers and the registered long_press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            hold_cnt   <= hold_next;
            long_done  <= long_done_next;
            long_press <= long_next;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
